// File: rtl/scan_pkg.sv
// Shared types for the scanning channel selector: controller states and mode encodings.
package scan_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StManual,
        StScan
    } state_e;

    localparam logic ModeManual = 1'b0;
    localparam logic ModeScan   = 1'b1;

endpackage

// File: rtl/scan_mux_decoder_if.sv
// Control, channel-bank and valid/ready output bundle of the scanning channel selector.
interface scan_mux_decoder_if #(
    parameter int unsigned CH_COUNT = 8,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned DATA_W   = 1,
    parameter int unsigned DWELL_W  = 4
) ();

    logic                       enable;
    logic                       mode;
    logic [SEL_W-1:0]           man_sel;
    logic [DWELL_W-1:0]         dwell;
    logic [CH_COUNT*DATA_W-1:0] ch_data;
    logic                       out_ready;
    logic                       out_valid;
    logic [DATA_W-1:0]          out_data;
    logic [SEL_W-1:0]           out_sel;
    logic [CH_COUNT-1:0]        out_onehot;
    logic                       sel_err;
    logic                       wrap;

    modport master (
        output enable, mode, man_sel, dwell, ch_data, out_ready,
        input  out_valid, out_data, out_sel, out_onehot, sel_err, wrap
    );

    modport slave (
        input  enable, mode, man_sel, dwell, ch_data, out_ready,
        output out_valid, out_data, out_sel, out_onehot, sel_err, wrap
    );

endinterface

// File: rtl/onehot_decoder.sv
// Combinational select-to-one-hot decoder; all-zero when sel is out of range.
module onehot_decoder #(
    parameter int unsigned SEL_W = 3,
    parameter int unsigned N_OUT = 8
) (
    input  logic [SEL_W-1:0] sel,
    output logic [N_OUT-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            onehot[k] = (32'(sel) == k);
        end
    end

endmodule

// File: rtl/scan_mux_decoder.sv
// Registered channel selector: manual select or round-robin scan with dwell, presented on a
// valid/ready output register together with its index and one-hot code.
module scan_mux_decoder
    import scan_pkg::*;
#(
    parameter int unsigned CH_COUNT = 8,
    parameter int unsigned SEL_W    = 3,
    parameter int unsigned DATA_W   = 1,
    parameter int unsigned DWELL_W  = 4
) (
    input logic               clk,
    input logic               rst_n,
    scan_mux_decoder_if.slave bus
);

    localparam logic [SEL_W-1:0] LastCh = SEL_W'(CH_COUNT - 1);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    scan_ptr_q, scan_ptr_d;
    logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CH_COUNT-1:0] onehot_q, onehot_d;
    logic                err_q, err_d;
    logic                wrap_q, wrap_d;

    logic                slot_free, switching, take_man, take_scan, sel_ok;
    logic [SEL_W-1:0]    take_sel;
    logic [DATA_W-1:0]   take_data;
    logic [CH_COUNT-1:0] take_onehot;

    onehot_decoder #(
        .SEL_W (SEL_W),
        .N_OUT (CH_COUNT)
    ) u_dec (
        .sel    (take_sel),
        .onehot (take_onehot)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            scan_ptr_q  <= '0;
            dwell_cnt_q <= '0;
            valid_q     <= 1'b0;
            data_q      <= '0;
            sel_q       <= '0;
            onehot_q    <= '0;
            err_q       <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            scan_ptr_q  <= scan_ptr_d;
            dwell_cnt_q <= dwell_cnt_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
            sel_q       <= sel_d;
            onehot_q    <= onehot_d;
            err_q       <= err_d;
            wrap_q      <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!bus.enable) begin
            state_d = StIdle;
        end else if (bus.mode == ModeScan) begin
            state_d = StScan;
        end else begin
            state_d = StManual;
        end
    end

    always_comb begin
        slot_free = !valid_q || bus.out_ready;
        // A state change consumes its cycle; the new state samples from the next one.
        switching = (state_d != state_q);
        take_man  = (state_q == StManual) && !switching && slot_free;
        take_scan = (state_q == StScan) && !switching && slot_free && (dwell_cnt_q == '0);
        take_sel  = take_scan ? scan_ptr_q : bus.man_sel;
        sel_ok    = (32'(take_sel) < CH_COUNT);

        take_data = '0;
        for (int unsigned k = 0; k < CH_COUNT; k++) begin
            if (32'(take_sel) == k) begin
                take_data = bus.ch_data[k*DATA_W +: DATA_W];
            end
        end

        scan_ptr_d  = scan_ptr_q;
        dwell_cnt_d = dwell_cnt_q;
        if (switching && (state_d == StScan)) begin
            scan_ptr_d  = '0;
            dwell_cnt_d = '0;
        end else if ((state_q == StScan) && !switching) begin
            if (dwell_cnt_q != '0) begin
                dwell_cnt_d = dwell_cnt_q - 1'b1;
            end else if (slot_free) begin
                scan_ptr_d  = (scan_ptr_q == LastCh) ? '0 : scan_ptr_q + 1'b1;
                dwell_cnt_d = bus.dwell;
            end
        end

        valid_d  = valid_q;
        data_d   = data_q;
        sel_d    = sel_q;
        onehot_d = onehot_q;
        err_d    = 1'b0;
        wrap_d   = 1'b0;
        if (take_man || take_scan) begin
            valid_d  = 1'b1;
            data_d   = take_data;
            sel_d    = take_sel;
            onehot_d = take_onehot;
            err_d    = !sel_ok;
            wrap_d   = take_scan && (scan_ptr_q == LastCh);
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_data   = data_q;
    assign bus.out_sel    = sel_q;
    assign bus.out_onehot = onehot_q;
    assign bus.sel_err    = err_q;
    assign bus.wrap       = wrap_q;

endmodule

// File: tb/tb_scan_mux_decoder.sv
// Scoreboard bench: an 8-channel scanner and a 6-channel manual instance with queued expectations.
module tb_scan_mux_decoder;

    typedef struct {
        logic       data;
        logic [2:0] sel;
        logic [7:0] onehot;
        logic       err;
        logic       wrap;
        int         gap;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    exp_t q8[$];
    exp_t q6[$];
    exp_t cur8;
    exp_t e6;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;
    int   since = 0;
    logic [7:0] ch8_pat = 8'b1010_0110;

    scan_mux_decoder_if #(.CH_COUNT(8), .SEL_W(3), .DATA_W(1), .DWELL_W(4)) bus8 ();
    scan_mux_decoder_if #(.CH_COUNT(6), .SEL_W(3), .DATA_W(1), .DWELL_W(4)) bus6 ();

    scan_mux_decoder #(.CH_COUNT(8), .SEL_W(3), .DATA_W(1), .DWELL_W(4)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    scan_mux_decoder #(.CH_COUNT(6), .SEL_W(3), .DATA_W(1), .DWELL_W(4)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk8(input int k, input int gap, input logic w);
        exp_t e;
        logic [7:0] one;
        one      = 8'h01;
        e.data   = ch8_pat[k];
        e.sel    = 3'(k);
        e.onehot = one << k;
        e.err    = 1'b0;
        e.wrap   = w;
        e.gap    = gap;
        return e;
    endfunction

    function automatic exp_t mk6(input logic d, input logic [2:0] s, input logic [7:0] oh,
                                 input logic err);
        exp_t e;
        e.data   = d;
        e.sel    = s;
        e.onehot = oh;
        e.err    = err;
        e.wrap   = 1'b0;
        e.gap    = 0;
        return e;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // New sample = valid now and not merely held over from a stalled previous cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            since      = 0;
        end else begin
            since++;
            if (bus8.out_valid && !(prev_valid && !prev_ready)) begin
                if (q8.size() == 0) begin
                    chk("dut8_unexpected_sample", 32'(bus8.out_sel), 32'hFFFF);
                end else begin
                    cur8 = q8.pop_front();
                    chk("dut8_data", 32'(bus8.out_data), 32'(cur8.data));
                    chk("dut8_sel", 32'(bus8.out_sel), 32'(cur8.sel));
                    chk("dut8_onehot", 32'(bus8.out_onehot), 32'(cur8.onehot));
                    chk("dut8_sel_err", 32'(bus8.sel_err), 32'(cur8.err));
                    chk("dut8_wrap", 32'(bus8.wrap), 32'(cur8.wrap));
                    if (cur8.gap != 0) chk("dut8_gap", since, cur8.gap);
                end
                since = 0;
            end else begin
                chk("dut8_idle_wrap", 32'(bus8.wrap), 32'h0);
                chk("dut8_idle_sel_err", 32'(bus8.sel_err), 32'h0);
                if (bus8.out_valid) begin
                    chk("dut8_held_data", 32'(bus8.out_data), 32'(cur8.data));
                    chk("dut8_held_sel", 32'(bus8.out_sel), 32'(cur8.sel));
                    chk("dut8_held_onehot", 32'(bus8.out_onehot), 32'(cur8.onehot));
                end
            end
            prev_valid = bus8.out_valid;
            prev_ready = bus8.out_ready;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus6.out_valid) begin
                if (q6.size() == 0) begin
                    chk("dut6_unexpected_sample", 32'(bus6.out_sel), 32'hFFFF);
                end else begin
                    e6 = q6.pop_front();
                    chk("dut6_data", 32'(bus6.out_data), 32'(e6.data));
                    chk("dut6_sel", 32'(bus6.out_sel), 32'(e6.sel));
                    chk("dut6_onehot", 32'(bus6.out_onehot), 32'(e6.onehot));
                    chk("dut6_sel_err", 32'(bus6.sel_err), 32'(e6.err));
                    chk("dut6_wrap", 32'(bus6.wrap), 32'h0);
                end
            end else begin
                chk("dut6_idle_sel_err", 32'(bus6.sel_err), 32'h0);
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        bus8.enable    = 1'b1;
        bus8.mode      = 1'b1;
        bus8.man_sel   = 3'd0;
        bus8.dwell     = 4'd0;
        bus8.ch_data   = 8'b1010_0110;
        bus8.out_ready = 1'b1;
        bus6.enable    = 1'b0;
        bus6.mode      = 1'b0;
        bus6.man_sel   = 3'd5;
        bus6.dwell     = 4'd0;
        bus6.ch_data   = 6'b10_1101;
        bus6.out_ready = 1'b1;

        // Back-to-back scan, return to channel 0, dwell of 2, backpressure at channel 3,
        // resume at 4, scan to 2, one manual sample, rescan from 0.
        for (int k = 0; k < 8; k++) q8.push_back(mk8(k, (k == 0) ? 0 : 1, k == 7));
        q8.push_back(mk8(0, 1, 1'b0));
        for (int k = 1; k < 4; k++) q8.push_back(mk8(k, 3, 1'b0));
        q8.push_back(mk8(4, 6, 1'b0));
        q8.push_back(mk8(5, 1, 1'b0));
        q8.push_back(mk8(6, 1, 1'b0));
        q8.push_back(mk8(7, 1, 1'b1));
        q8.push_back(mk8(0, 1, 1'b0));
        q8.push_back(mk8(1, 1, 1'b0));
        q8.push_back(mk8(2, 1, 1'b0));
        q8.push_back(mk8(5, 2, 1'b0));
        q8.push_back(mk8(0, 2, 1'b0));

        q6.push_back(mk6(1'b1, 3'd5, 8'h20, 1'b0));
        q6.push_back(mk6(1'b0, 3'd7, 8'h00, 1'b1));
        q6.push_back(mk6(1'b1, 3'd0, 8'h01, 1'b0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 32'(bus8.out_valid), 32'h0);
        chk("reset_data", 32'(bus8.out_data), 32'h0);
        chk("reset_sel", 32'(bus8.out_sel), 32'h0);
        chk("reset_onehot", 32'(bus8.out_onehot), 32'h0);
        chk("reset_flags", {30'h0, bus8.sel_err, bus8.wrap}, 32'h0);
        chk("reset_valid6", 32'(bus6.out_valid), 32'h0);

        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1);
        chk("release_edge1_valid", 32'(bus8.out_valid), 32'h0);
        step(1);
        chk("release_edge2_valid", 32'(bus8.out_valid), 32'h1);
        chk("release_edge2_onehot", 32'(bus8.out_onehot), 32'h01);

        step(7);
        bus8.dwell = 4'd2;
        step(10);
        bus8.out_ready = 1'b0;
        step(5);
        bus8.out_ready = 1'b1;
        bus8.dwell     = 4'd0;
        step(7);
        bus8.mode    = 1'b0;
        bus8.man_sel = 3'd5;
        step(2);
        bus8.mode    = 1'b1;
        bus8.man_sel = 3'd6;
        step(2);
        bus8.out_ready = 1'b0;
        step(1);
        bus8.enable = 1'b0;
        step(3);
        chk("idle_hold_valid", 32'(bus8.out_valid), 32'h1);
        bus8.out_ready = 1'b1;
        step(1);
        chk("idle_accept_valid", 32'(bus8.out_valid), 32'h0);

        bus6.enable = 1'b1;
        step(2);
        bus6.man_sel = 3'd7;
        step(1);
        bus6.man_sel = 3'd0;
        step(1);
        bus6.enable = 1'b0;
        step(3);
        chk("dut6_idle_valid", 32'(bus6.out_valid), 32'h0);

        chk("dut8_queue_left", q8.size(), 32'h0);
        chk("dut6_queue_left", q6.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
